// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC sequencing controller.
package rtc_pkg;

  localparam int RTC_REG_COUNT = 6;
  localparam int BUS_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_COMMIT   = 3'd5
  } state_t;

  // Register addresses in sweep order: seg, min, hour, day, month, year (LSB first).
  localparam logic [RTC_REG_COUNT*BUS_W-1:0] ADDR_TABLE =
    {8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};

  function automatic logic [BUS_W-1:0] reg_addr(input logic [2:0] idx);
    return ADDR_TABLE[int'(idx)*BUS_W +: BUS_W];
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh counter; sweep_tick pulses in the cycle the count wraps.
module rtc_refresh_timer #(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic sweep_tick
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign sweep_tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset)           count <= '0;
    else if (sweep_tick) count <= '0;
    else                 count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/rtc_scheduler.sv
// Sweeps the six RTC time registers through the bus engine, arbitrates user writes,
// and commits time atomically. Optional watchdog: define RTC_SCHED_TIMEOUT_EN.
module rtc_scheduler
  import rtc_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_req,
  input  logic [BUS_W-1:0] write_addr,
  input  logic [BUS_W-1:0] write_data,
  output logic             write_ack,
  output logic             bus_start,
  output logic             bus_we,
  output logic [BUS_W-1:0] bus_addr,
  output logic [BUS_W-1:0] bus_wdata,
  input  logic             bus_done,
  input  logic [BUS_W-1:0] bus_rdata,
  output logic [BUS_W-1:0] seg,
  output logic [BUS_W-1:0] min,
  output logic [BUS_W-1:0] hour,
  output logic [BUS_W-1:0] day,
  output logic [BUS_W-1:0] month,
  output logic [BUS_W-1:0] year,
  output logic             time_valid,
  output logic             busy,
  output logic             err
);

  if (REFRESH_CYCLES < 64 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 2047) begin : g_bad_cfg
    $error("rtc_scheduler: unsupported REFRESH_CYCLES/TIMEOUT_CYCLES");
  end

  state_t           state, state_nxt;
  logic [2:0]       idx;
  logic             sweep_pending;
  logic             sweep_tick;
  logic             take_sweep, wr_done, rd_done, timeout_hit;
  logic [BUS_W-1:0] shadow [RTC_REG_COUNT];

  rtc_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .sweep_tick (sweep_tick)
  );

`ifdef RTC_SCHED_TIMEOUT_EN
  logic [10:0] wd_cnt;
  logic        in_wait;

  assign in_wait     = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
  assign timeout_hit = in_wait && !bus_done && (wd_cnt == 11'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (timeout_hit) err <= 1'b1;
      if (in_wait && !bus_done && !timeout_hit) wd_cnt <= wd_cnt + 11'd1;
      else                                      wd_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    take_sweep = 1'b0;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (write_req) state_nxt = ST_WR_ISSUE;
        else if (sweep_pending) begin
          take_sweep = 1'b1;
          state_nxt  = ST_RD_ISSUE;
        end
      end
      ST_WR_ISSUE: state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (bus_done) begin
          wr_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (bus_done) begin
          rd_done   = 1'b1;
          state_nxt = (idx == 3'(RTC_REG_COUNT - 1)) ? ST_COMMIT : ST_RD_ISSUE;
        end else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign bus_start  = (state == ST_WR_ISSUE) || (state == ST_RD_ISSUE);
  assign write_ack  = wr_done;
  assign time_valid = (state == ST_COMMIT);
  assign busy       = (state != ST_IDLE);

  // Bus request fields are registered on entry to an issue state so they are
  // already stable in the bus_start cycle and hold until bus_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      sweep_pending <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      for (int i = 0; i < RTC_REG_COUNT; i++) shadow[i] <= '0;
      {seg, min, hour, day, month, year} <= '0;
    end else begin
      state         <= state_nxt;
      // A refresh wrap or a completed write both request one sweep; they never queue.
      sweep_pending <= (sweep_pending && !take_sweep) || sweep_tick || wr_done;
      if (state == ST_IDLE && write_req) begin
        bus_we    <= 1'b1;
        bus_addr  <= write_addr;
        bus_wdata <= write_data;
      end
      if (take_sweep) begin
        idx      <= '0;
        bus_we   <= 1'b0;
        bus_addr <= reg_addr(3'd0);
      end
      if (rd_done) begin
        shadow[idx] <= bus_rdata;
        if (idx != 3'(RTC_REG_COUNT - 1)) begin
          idx      <= idx + 3'd1;
          bus_addr <= reg_addr(idx + 3'd1);
        end
      end
      if (state == ST_COMMIT) begin
        seg   <= shadow[0];
        min   <= shadow[1];
        hour  <= shadow[2];
        day   <= shadow[3];
        month <= shadow[4];
        year  <= shadow[5];
      end
    end
  end

endmodule
